// File: rtl/zombie_hit.sv
// zombie_hit: resolves player attack hitboxes against one zombie and runs its
// health / hurt / dying / dead / respawn animation on frame ticks.
// Optional health bar overlay: define HEALTH_BAR_EN to build the is_bar logic.
module zombie_hit #(
  parameter int unsigned ATK_W          = 16,
  parameter int unsigned ATK_H          = 16,
  parameter int unsigned ZMB_W          = 32,
  parameter int unsigned ZMB_H          = 48,
  parameter int unsigned MAX_HP         = 3,
  parameter int unsigned DAMAGE         = 1,
  parameter int unsigned HIT_FRAMES     = 8,
  parameter int unsigned DEATH_FRAMES   = 30,
  parameter int unsigned RESPAWN_FRAMES = 120,
  parameter int unsigned BAR_SEG        = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       Attack_On,
  input  logic [9:0] Attack_X,
  input  logic [9:0] Attack_Y,
  input  logic [9:0] Zombie_X,
  input  logic [9:0] Zombie_Y,
  input  logic [8:0] PixelX,
  input  logic [8:0] PixelY,
  output logic [1:0] Zombie_State,
  output logic [3:0] Health,
  output logic       Kill_Pulse,
  output logic       Respawn_Pulse,
  output logic [7:0] Kill_Count,
  output logic       is_bar
);

  localparam int unsigned MAX_HD  = (HIT_FRAMES > DEATH_FRAMES) ? HIT_FRAMES : DEATH_FRAMES;
  localparam int unsigned MAX_FR  = (MAX_HD > RESPAWN_FRAMES) ? MAX_HD : RESPAWN_FRAMES;
  localparam int unsigned CNT_W   = $clog2(MAX_FR + 1);
  localparam int unsigned HP_W    = 4;
  localparam int unsigned KC_W    = 8;
  localparam int unsigned POS_W   = 11;

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_HURT  = 2'd1,
    ST_DYING = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [HP_W-1:0]   health_q, health_nxt;
  logic [KC_W-1:0]   kc_q, kc_nxt;
  logic              kp_q, kp_nxt;
  logic              rp_q, rp_nxt;
  logic              fr_s, fr_d, tick_q;
  logic              overlap_c;
  logic              bar_c;
  logic              is_bar_q;

  logic [POS_W-1:0] ax, ay, zx, zy;
  assign ax = POS_W'(Attack_X);
  assign ay = POS_W'(Attack_Y);
  assign zx = POS_W'(Zombie_X);
  assign zy = POS_W'(Zombie_Y);

  // Strict box overlap; touching edges do not count
  assign overlap_c = (ax < zx + POS_W'(ZMB_W)) && (zx < ax + POS_W'(ATK_W)) &&
                     (ay < zy + POS_W'(ZMB_H)) && (zy < ay + POS_W'(ATK_H));

  // Frame clock synchroniser and one-Clk rising-edge tick
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fr_s   <= 1'b0;
      fr_d   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      fr_s   <= frame_clk;
      fr_d   <= fr_s;
      tick_q <= fr_s & ~fr_d;
    end
  end

  // State register with health, timer, kill counter and pulses
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= ST_ALIVE;
      cnt_q    <= '0;
      health_q <= HP_W'(MAX_HP);
      kc_q     <= '0;
      kp_q     <= 1'b0;
      rp_q     <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      health_q <= health_nxt;
      kc_q     <= kc_nxt;
      kp_q     <= kp_nxt;
      rp_q     <= rp_nxt;
    end
  end

  // Next-state logic: hits only land while alive, timers count frame ticks
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    health_nxt = health_q;
    kc_nxt     = kc_q;
    kp_nxt     = 1'b0;
    rp_nxt     = 1'b0;
    if (tick_q) begin
      case (state_q)
        ST_ALIVE: begin
          if (Attack_On && overlap_c) begin
            if (health_q <= HP_W'(DAMAGE)) begin
              health_nxt = '0;
              state_nxt  = ST_DYING;
              cnt_nxt    = CNT_W'(DEATH_FRAMES);
              kp_nxt     = 1'b1;
              if (kc_q != {KC_W{1'b1}}) kc_nxt = kc_q + KC_W'(1);
            end else begin
              health_nxt = health_q - HP_W'(DAMAGE);
              state_nxt  = ST_HURT;
              cnt_nxt    = CNT_W'(HIT_FRAMES);
            end
          end
        end
        ST_HURT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_nxt = ST_ALIVE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q - CNT_W'(1);
          end
        end
        ST_DYING: begin
          if (cnt_q == CNT_W'(1)) begin
            state_nxt = ST_DEAD;
            cnt_nxt   = CNT_W'(RESPAWN_FRAMES);
          end else begin
            cnt_nxt = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          if (cnt_q == CNT_W'(1)) begin
            state_nxt  = ST_ALIVE;
            cnt_nxt    = '0;
            health_nxt = HP_W'(MAX_HP);
            rp_nxt     = 1'b1;
          end else begin
            cnt_nxt = cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Output mapping from registered state
  always_comb begin
    Zombie_State  = state_q;
    Health        = health_q;
    Kill_Pulse    = kp_q;
    Respawn_Pulse = rp_q;
    Kill_Count    = kc_q;
    is_bar        = is_bar_q;
  end

`ifdef HEALTH_BAR_EN
  logic [POS_W-1:0] px, py, bar_end;
  assign px      = POS_W'(PixelX);
  assign py      = POS_W'(PixelY);
  assign bar_end = zx + POS_W'(health_q) * POS_W'(BAR_SEG);

  // Health bar: four rows above the zombie, Health*BAR_SEG pixels long
  always_comb begin
    bar_c = 1'b0;
    if ((state_q == ST_ALIVE || state_q == ST_HURT) && (zy >= POS_W'(6)) &&
        (py >= zy - POS_W'(6)) && (py <= zy - POS_W'(3)) &&
        (px >= zx) && (px < bar_end))
      bar_c = 1'b1;
  end
`else
  logic unused_pixels;
  assign unused_pixels = ^{PixelX, PixelY};
  assign bar_c = 1'b0;
`endif

  // Registered health-bar pixel flag
  always_ff @(posedge Clk) begin
    if (!Reset_n) is_bar_q <= 1'b0;
    else          is_bar_q <= bar_c;
  end

endmodule

// File: doc/zombie_hit.md
# zombie_hit

Hit-receiving end of the player attack path: consumes the attack hitbox the player attack logic drives (on flag plus 16×16 box position) and resolves hits against one zombie. Tracks zombie health, hurt invulnerability, death animation and respawn in a frame-tick-driven state machine. Emits state, health, kill pulse and kill count to game logic, and optionally a health-bar pixel flag to the colour mapper.

## Interface
- ATK_W, 16: attack box width (px)
- ATK_H, 16: attack box height (px)
- ZMB_W, 32: zombie box width (px)
- ZMB_H, 48: zombie box height (px)
- MAX_HP, 3: health on reset/respawn (1..15)
- DAMAGE, 1: health removed per hit (1..15)
- HIT_FRAMES, 8: frame ticks spent in HURT (≥1)
- DEATH_FRAMES, 30: frame ticks spent in DYING (≥1)
- RESPAWN_FRAMES, 120: frame ticks spent in DEAD (≥1)
- BAR_SEG, 8: health-bar px per health point
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  synchronous, active-low reset
- frame_clk  in  1  frame clock (~60 Hz), asynchronous level
- Attack_On  in  1  attack box active
- Attack_X, Attack_Y  in  10 each  attack box top-left
- Zombie_X, Zombie_Y  in  10 each  zombie box top-left
- PixelX, PixelY  in  9 each  current draw pixel
- Zombie_State  out  2  0=ALIVE, 1=HURT, 2=DYING, 3=DEAD
- Health  out  4  current health
- Kill_Pulse  out  1  one-cycle pulse on kill
- Respawn_Pulse  out  1  one-cycle pulse on respawn
- Kill_Count  out  8  saturating kill counter
- is_bar  out  1  current pixel is on health bar

## Operation
- Tick: frame_clk registered; rising edge registered again → tick, one Clk wide per frame edge.
- Overlap (11-bit sums, no wrap): Attack_X < Zombie_X+ZMB_W, Zombie_X < Attack_X+ATK_W, same for Y with heights. Touching edges = no overlap.
- Hit = tick & Attack_On & overlap & state==ALIVE. Hits in HURT/DYING/DEAD ignored.
- ALIVE, hit: Health ← max(Health−DAMAGE, 0). Result 0 → DYING, cnt←DEATH_FRAMES, Kill_Pulse, Kill_Count+1 (saturates at 255). Else → HURT, cnt←HIT_FRAMES.
- HURT/DYING/DEAD, tick: cnt==1 → next state (HURT→ALIVE, DYING→DEAD with cnt←RESPAWN_FRAMES, DEAD→ALIVE with Health←MAX_HP and Respawn_Pulse); else cnt−1. Each state lasts exactly its parameter in ticks.
- Attack_On held continuously: one hit per ALIVE entry; HURT expiry with overlap still present → hit on first tick after re-entering ALIVE, not same tick.
- Kill_Count not cleared on respawn; cleared only by reset.

## Timing
- Reset (Reset_n low at Clk edge): Zombie_State=0, Health=MAX_HP, cnt=0, Kill_Pulse=0, Respawn_Pulse=0, Kill_Count=0, tick pipeline=0, is_bar=0 (registered). Reset mid-animation aborts it immediately.
- frame_clk edge → tick: 2 Clk cycles. Tick → state/Health/Kill_Count update and pulse: 1 Clk cycle (registered outputs).
- Attack/zombie positions sampled only on tick cycle; changes between ticks have no effect.
- Kill_Pulse and Respawn_Pulse high exactly one Clk cycle, never simultaneously.
- is_bar: 1-cycle registered pipeline from PixelX/PixelY.

## Configuration
- HEALTH_BAR_EN defined: is_bar=1 when state ∈ {ALIVE, HURT}, Zombie_Y ≥ 6, Zombie_Y−6 ≤ PixelY ≤ Zombie_Y−3, Zombie_X ≤ PixelX < Zombie_X+Health·BAR_SEG (11-bit compare). Bar suppressed when Zombie_Y < 6.
- HEALTH_BAR_EN undefined: is_bar tied 0, bar logic absent; all other behaviour identical.

## Test plan
- Reset, Attack_On=1, attack (100,100), zombie (110,90) overlapping, one frame edge → 3 Clk later Health=2, Zombie_State=1; 8 further ticks → state 0.
- Attack held overlapping from reset, default params → Health 3→2→1→0 on ticks 1, 10, 19; Kill_Pulse 1 cycle, Kill_Count=1, state 2; 30 ticks later state 3; 120 ticks later state 0, Health=3, Respawn_Pulse 1 cycle.
- Attack_X = Zombie_X+ZMB_W (edge touching), Attack_On=1, tick → no hit, Health=3; Attack_X−1 → hit.
- Drive 256 kills (RESPAWN/DEATH/HIT_FRAMES=1, MAX_HP=1) → Kill_Count saturates at 255.
- Reset_n low during DYING → next cycle state 0, Health=3, Kill_Count=0; no pulses.
- HEALTH_BAR_EN on, zombie (200,100), Health=2 → is_bar=1 at pixel (215,95), 0 at (216,95) and (215,98); Zombie_Y=4 → is_bar=0 everywhere.
